// File: rtl/serial_load_ctrl_pkg.sv
// Shared types and constants for the two-requester serial load controller.
package serial_load_ctrl_pkg;

    localparam int WIDTH_DEF = 16;

    // Bit counter only has to reach WIDTH-1, so a width of one is enough for WIDTH <= 2.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/serial_load_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            grant_o = ~last_i;
        end else begin
            grant_o = req_i[1];
        end
    end

endmodule

// File: rtl/serial_load_ctrl.sv
// Serialises a WIDTH-bit load from one of two requesters into a shared shift
// register, then presents the captured word with a valid/ready handshake.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | waiting for a request; arbiter picks the grant
//   ST_SHIFT   | forwarding granted requester's bits into the shift reg
//   ST_CAPTURE | one cycle: latch shift register contents and source
//   ST_OUT     | word presented until the consumer accepts it
module serial_load_ctrl
    import serial_load_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_i,
    input  logic [1:0]       bit_i,
    input  logic [1:0]       bit_valid_i,
    output logic [1:0]       bit_ready_o,
    output logic             sr_en_o,
    output logic             sr_in_o,
    input  logic [WIDTH-1:0] sr_data_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_src_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             busy_o
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               g_q, g_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               src_q, src_d;

    logic               arb_grant;
    logic               arb_valid;
    logic               bit_acc;
    logic               last_bit;
    logic               word_hs;

    rr_arb2 u_arb (
        .req_i   (req_i),
        .last_i  (last_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    assign bit_acc  = (state_q == ST_SHIFT) && bit_valid_i[g_q];
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign word_hs  = (state_q == ST_OUT) && word_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (arb_valid) state_d = ST_SHIFT;
            ST_SHIFT:   if (bit_acc && last_bit) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_OUT;
            ST_OUT:     if (word_ready_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_ready_o  = 2'b00;
        sr_en_o      = 1'b0;
        sr_in_o      = 1'b0;
        word_valid_o = (state_q == ST_OUT);
        busy_o       = (state_q != ST_IDLE);
        if (state_q == ST_SHIFT) begin
            bit_ready_o[g_q] = 1'b1;
            sr_en_o          = bit_valid_i[g_q];
            sr_in_o          = bit_i[g_q];
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        g_d    = g_q;
        last_d = last_q;
        word_d = word_q;
        src_d  = src_q;
        if (bit_acc) begin
            cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
        end
        if ((state_q == ST_IDLE) && arb_valid) begin
            g_d = arb_grant;
        end
        if (state_q == ST_CAPTURE) begin
            word_d = sr_data_i;
            src_d  = g_q;
        end
        // Fairness pointer moves only once the word has actually been taken.
        if (word_hs) begin
            last_d = g_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            g_q    <= 1'b0;
            last_q <= 1'b1;
            word_q <= '0;
            src_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            g_q    <= g_d;
            last_q <= last_d;
            word_q <= word_d;
            src_q  <= src_d;
        end
    end

    assign word_o     = word_q;
    assign word_src_o = src_q;

endmodule
